// File: rtl/branch_predictor.sv
// Bimodal BHT of 2-bit saturating counters; define BRANCH_PREDICTOR_GSHARE_EN to XOR the index with a global history.
// Prediction is combinational (zero latency); training and statistics commit on the rising edge; never stalls.
module branch_predictor #(
  parameter int INDEX_W = 6,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_is_cond,
  input  logic              upd_token,
  input  logic              upd_pred_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] cond_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;

  logic [1:0]         r_bht [ENTRIES];
  logic [STAT_W-1:0]  r_cond_cnt;
  logic [STAT_W-1:0]  r_miss_cnt;
  logic [INDEX_W-1:0] w_pred_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic [1:0]         w_upd_ctr;
  logic               w_train;
  logic               w_miss;
  logic               w_unused_pc;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [INDEX_W-1:0] r_ghr;

  // Prediction and training both hash with the pre-edge history.
  assign w_pred_idx = pred_pc[INDEX_W+1:2] ^ r_ghr;
  assign w_upd_idx  = upd_pc[INDEX_W+1:2] ^ r_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_train) begin
      r_ghr <= {r_ghr[INDEX_W-2:0], upd_token};
    end
  end
`else
  assign w_pred_idx = pred_pc[INDEX_W+1:2];
  assign w_upd_idx  = upd_pc[INDEX_W+1:2];
`endif

  // Word-aligned PCs: low two bits and the untagged upper bits never reach the table.
  assign w_unused_pc = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0], upd_pc[31:INDEX_W+2], upd_pc[1:0]};

  assign w_train    = upd_en & upd_is_cond;
  assign w_miss     = w_train & (upd_token ^ upd_pred_taken);
  assign w_upd_ctr  = r_bht[w_upd_idx];

  assign pred_taken = pred_req & r_bht[w_pred_idx][1];
  assign mispredict = w_miss;
  assign cond_cnt   = r_cond_cnt;
  assign miss_cnt   = r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_train) begin
      if (upd_token && (w_upd_ctr != 2'b11)) begin
        r_bht[w_upd_idx] <= w_upd_ctr + 2'd1;
      end else if (!upd_token && (w_upd_ctr != 2'b00)) begin
        r_bht[w_upd_idx] <= w_upd_ctr - 2'd1;
      end
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_train && (r_cond_cnt != '1)) begin
        r_cond_cnt <= r_cond_cnt + STAT_W'(1);
      end
      if (w_miss && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + STAT_W'(1);
      end
    end
  end

endmodule
